// File: rtl/genesis_pad_input_filter_if.sv
// -----------------------------------------------------------------------------
// genesis_pad_input_filter_if
// Groups the pad-side signals of the DB9 input filter.
//   iPAD_RAW      : raw pad pins, active low, externally pulled up
//   oGENPAD       : filtered pin vector, same bit order as iPAD_RAW
//   oPAD_IDLE     : high while the filtered vector has been all-ones long enough
//   oGLITCH_COUNT : saturating glitch event counter (zero when not built in)
// Modports:
//   slave  : the filter itself (consumes raw pins, produces filtered outputs)
//   master : the environment (drives raw pins, observes filtered outputs)
// -----------------------------------------------------------------------------
interface genesis_pad_input_filter_if;
  logic [5:0] iPAD_RAW;
  logic [5:0] oGENPAD;
  logic       oPAD_IDLE;
  logic [7:0] oGLITCH_COUNT;

  modport slave (
    input  iPAD_RAW,
    output oGENPAD,
    output oPAD_IDLE,
    output oGLITCH_COUNT
  );

  modport master (
    output iPAD_RAW,
    input  oGENPAD,
    input  oPAD_IDLE,
    input  oGLITCH_COUNT
  );
endinterface

// File: rtl/genesis_pad_input_filter.sv
// -----------------------------------------------------------------------------
// genesis_pad_input_filter
// Input conditioning for the six DB9 gamepad pins ahead of genesis_gamepads.
// Each raw pin is synchronised into the iCLK domain, then passed through a
// per-bit stability filter: the output bit only follows the synchronised pin
// once it has disagreed with the output for STABLE_CYCLES consecutive cycles.
// A long run of filtered all-ones (pad released or unplugged) raises oPAD_IDLE.
//
// Ports:
//   iCLK      : system clock (50 MHz)
//   iN_RESET  : asynchronous active-low reset
//   pad       : genesis_pad_input_filter_if.slave
//               (iPAD_RAW in, oGENPAD / oPAD_IDLE / oGLITCH_COUNT out)
//
// Optional feature macro: GENPAD_GLITCH_COUNT_EN
//   When defined, oGLITCH_COUNT counts glitch events (a pin that started to
//   change but returned before qualifying), summed over all bits and
//   saturating at 255. When undefined, oGLITCH_COUNT is constant zero and no
//   counter logic exists.
// -----------------------------------------------------------------------------
module genesis_pad_input_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int IDLE_CYCLES   = 1048576
) (
  input  logic                          iCLK,
  input  logic                          iN_RESET,
  genesis_pad_input_filter_if.slave     pad
);

  localparam logic [7:0]  STABLE_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [19:0] IDLE_LAST   = 20'(IDLE_CYCLES - 1);
  localparam logic [5:0]  ALL_RELEASED = 6'b111111;

  // Synchroniser chain: index 0 samples the pins, the top index is sync_s.
  logic [SYNC_STAGES-1:0][5:0] sync_r;
  logic [5:0]                  sync_s;

  logic [5:0]                  genpad_r;
  logic [5:0]                  genpad_nxt_s;
  logic [5:0][7:0]             cnt_r;
  logic [5:0][7:0]             cnt_nxt_s;

  logic [19:0]                 idle_cnt_r;
  logic                        pad_idle_r;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Shift raw pins through the synchroniser; reset to the released level.
  always_ff @(posedge iCLK or negedge iN_RESET) begin
    if (!iN_RESET) begin
      sync_r <= '1;
    end else begin
      sync_r[0] <= pad.iPAD_RAW;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

`ifdef GENPAD_GLITCH_COUNT_EN
  logic [5:0] glitch_vec_s;
  logic [7:0] glitch_cnt_r;

  // Number of bits set in a 6-bit event vector.
  function automatic logic [2:0] count_ones6(input logic [5:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int b = 0; b < 6; b++) begin
      n = n + {2'd0, v[b]};
    end
    return n;
  endfunction

  // Add an increment to an 8-bit counter, clamping at 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [2:0] inc);
    logic [8:0] sum;
    sum = {1'b0, base} + {6'd0, inc};
    return sum[8] ? 8'd255 : sum[7:0];
  endfunction
`endif

  // Per-bit stability filter next state; a glitch is a bit whose counter was
  // running but whose synchronised value fell back to the current output.
  always_comb begin
    genpad_nxt_s = genpad_r;
    cnt_nxt_s    = '0;
`ifdef GENPAD_GLITCH_COUNT_EN
    glitch_vec_s = 6'd0;
`endif
    for (int i = 0; i < 6; i++) begin
      if (sync_s[i] == genpad_r[i]) begin
        cnt_nxt_s[i] = 8'd0;
`ifdef GENPAD_GLITCH_COUNT_EN
        glitch_vec_s[i] = (cnt_r[i] != 8'd0);
`endif
      end else if (cnt_r[i] == STABLE_LAST) begin
        genpad_nxt_s[i] = sync_s[i];
        cnt_nxt_s[i]    = 8'd0;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + 8'd1;
      end
    end
  end

  // Filter state registers; output starts released.
  always_ff @(posedge iCLK or negedge iN_RESET) begin
    if (!iN_RESET) begin
      genpad_r <= ALL_RELEASED;
      cnt_r    <= '0;
    end else begin
      genpad_r <= genpad_nxt_s;
      cnt_r    <= cnt_nxt_s;
    end
  end

  // Idle detector: counts cycles of filtered all-ones, holds at the terminal
  // count so oPAD_IDLE stays up until a pin qualifies low.
  always_ff @(posedge iCLK or negedge iN_RESET) begin
    if (!iN_RESET) begin
      idle_cnt_r <= 20'd0;
      pad_idle_r <= 1'b0;
    end else if (genpad_r != ALL_RELEASED) begin
      idle_cnt_r <= 20'd0;
      pad_idle_r <= 1'b0;
    end else if (idle_cnt_r == IDLE_LAST) begin
      idle_cnt_r <= idle_cnt_r;
      pad_idle_r <= 1'b1;
    end else begin
      idle_cnt_r <= idle_cnt_r + 20'd1;
      pad_idle_r <= pad_idle_r;
    end
  end

`ifdef GENPAD_GLITCH_COUNT_EN
  // Saturating glitch counter, cleared only by reset.
  always_ff @(posedge iCLK or negedge iN_RESET) begin
    if (!iN_RESET) begin
      glitch_cnt_r <= 8'd0;
    end else begin
      glitch_cnt_r <= sat_add8(glitch_cnt_r, count_ones6(glitch_vec_s));
    end
  end

  assign pad.oGLITCH_COUNT = glitch_cnt_r;
`else
  assign pad.oGLITCH_COUNT = 8'd0;
`endif

  assign pad.oGENPAD   = genpad_r;
  assign pad.oPAD_IDLE = pad_idle_r;

endmodule

// File: tb/tb_genesis_pad_input_filter.sv
// -----------------------------------------------------------------------------
// tb_genesis_pad_input_filter
// Scoreboard bench: every clock edge the reference model predicts the
// registered outputs and queues them; a negedge monitor pops and compares.
// Reference model: a pin's output flips once the last STABLE samples of the
// synchronised pin all disagree with it; idle is a run-length of all-ones.
// -----------------------------------------------------------------------------
module tb_genesis_pad_input_filter;
  localparam int SYNC   = 2;
  localparam int STABLE = 16;
  localparam int IDLE   = 100;

  logic iCLK = 1'b0;
  logic iN_RESET;
  always #5 iCLK = ~iCLK;

  genesis_pad_input_filter_if pad_if ();

  genesis_pad_input_filter #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE),
    .IDLE_CYCLES   (IDLE)
  ) u_dut (
    .iCLK     (iCLK),
    .iN_RESET (iN_RESET),
    .pad      (pad_if.slave)
  );

  typedef struct {
    logic [5:0] gp;
    logic       idle;
    logic [7:0] gl;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [5:0] raw_pipe[$];
  logic [5:0] hist[$];
  logic [5:0] m_out;
  logic       m_idle;
  int         m_gl;
  int         run_len;
  bit         mon_en = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    raw_pipe.delete();
    hist.delete();
    for (int k = 0; k < SYNC; k++) raw_pipe.push_back(6'h3F);
    for (int k = 0; k < STABLE; k++) hist.push_back(6'h3F);
    m_out   = 6'h3F;
    m_idle  = 1'b0;
    m_gl    = 0;
    run_len = 0;
  endtask

  // One clock edge of the reference: raw is the value sampled at this edge.
  task automatic model_step(input logic [5:0] raw);
    logic [5:0] s, prev, nout, drop;
    int         ev;
    bit         all_diff;
    exp_t       e;
    s = raw_pipe.pop_front();
    raw_pipe.push_back(raw);
    prev = hist[hist.size()-1];
    hist.push_back(s);
    drop = hist.pop_front();
    nout = m_out;
    ev   = 0;
    for (int b = 0; b < 6; b++) begin
      all_diff = 1'b1;
      foreach (hist[k]) if (hist[k][b] == m_out[b]) all_diff = 1'b0;
      if (all_diff) nout[b] = ~m_out[b];
      if (s[b] == m_out[b] && prev[b] != m_out[b]) ev++;
    end
    if (m_out == 6'h3F) run_len++;
    else run_len = 0;
    m_idle = (m_out == 6'h3F) && (run_len >= IDLE);
`ifdef GENPAD_GLITCH_COUNT_EN
    m_gl = (m_gl + ev > 255) ? 255 : m_gl + ev;
`else
    m_gl = 0;
`endif
    m_out = nout;
    e.gp   = m_out;
    e.idle = m_idle;
    e.gl   = 8'(m_gl);
    exp_q.push_back(e);
  endtask

  task automatic tick(input logic [5:0] raw);
    pad_if.iPAD_RAW = raw;
    @(posedge iCLK);
    model_step(raw);
    #1;
  endtask

  // Monitor: outputs are presented every cycle; compare against the queue.
  always @(negedge iCLK) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'd0, 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_genpad", {26'd0, pad_if.oGENPAD}, {26'd0, mon_e.gp});
        check("sb_idle", {31'd0, pad_if.oPAD_IDLE}, {31'd0, mon_e.idle});
        check("sb_glitch", {24'd0, pad_if.oGLITCH_COUNT}, {24'd0, mon_e.gl});
      end
    end
  end

  initial begin
    int t;
    int first;
    int lows;
    int bad;
    logic [5:0] a;
    int exp_gl;

    iN_RESET = 1'b0;
    pad_if.iPAD_RAW = 6'h3F;
    repeat (3) @(posedge iCLK);
    #1;
    check("rst_genpad", {26'd0, pad_if.oGENPAD}, 32'h3F);
    check("rst_idle", {31'd0, pad_if.oPAD_IDLE}, 32'd0);
    check("rst_glitch", {24'd0, pad_if.oGLITCH_COUNT}, 32'd0);
    @(negedge iCLK);
    iN_RESET = 1'b1;
    #1;
    model_reset();
    mon_en = 1'b1;

    // Idle rises after IDLE cycles of filtered all-ones.
    t = 0;
    do begin tick(6'h3F); t++; end while (pad_if.oPAD_IDLE !== 1'b1 && t < 200);
    check("idle_rise_cycle", t, IDLE);

    // Bit 0 drops 18 cycles after the step; idle falls one cycle later.
    t = 0;
    do begin tick(6'h3E); t++; end while (pad_if.oGENPAD[0] !== 1'b0 && t < 40);
    check("step_bit0_latency", t, SYNC + STABLE);
    check("idle_at_drop", {31'd0, pad_if.oPAD_IDLE}, 32'd1);
    tick(6'h3E);
    check("idle_fall", {31'd0, pad_if.oPAD_IDLE}, 32'd0);
    repeat (30) tick(6'h3F);

`ifdef GENPAD_GLITCH_COUNT_EN
    exp_gl = 1;
`else
    exp_gl = 0;
`endif
    // 10-cycle pulse on bit 5 is rejected.
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick(k < 10 ? 6'h1F : 6'h3F);
      if (pad_if.oGENPAD !== 6'h3F) bad++;
    end
    check("pulse10_rejected", bad, 0);
    check("pulse10_glitch", {24'd0, pad_if.oGLITCH_COUNT}, exp_gl);

    // 15-cycle pulse is the longest that is still rejected.
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick(k < 15 ? 6'h1F : 6'h3F);
      if (pad_if.oGENPAD[5] !== 1'b1) bad++;
    end
    check("pulse15_rejected", bad, 0);
    check("pulse15_glitch", {24'd0, pad_if.oGLITCH_COUNT}, exp_gl * 2);

    // 16-cycle pulse qualifies: low at 18 cycles after onset, and returning
    // high needs its own full qualification window.
    first = -1;
    lows  = 0;
    for (int k = 1; k <= 60; k++) begin
      tick(k <= 16 ? 6'h1F : 6'h3F);
      if (pad_if.oGENPAD[5] === 1'b0) begin
        lows++;
        if (first < 0) first = k;
      end
    end
    check("pulse16_onset", first, SYNC + STABLE);
    check("pulse16_low_len", lows, STABLE);
    check("pulse16_glitch", {24'd0, pad_if.oGLITCH_COUNT}, exp_gl * 2);

    // Clean two-bit step: only bits 1:0 go low.
    t = 0;
    do begin tick(6'h3C); t++; end while (pad_if.oGENPAD[1:0] !== 2'b00 && t < 40);
    check("step_bits10_latency", t, SYNC + STABLE);
    check("step_other_bits", {26'd0, pad_if.oGENPAD}, 32'h3C);
    repeat (30) tick(6'h3F);

    // Randomised traffic: alternating select-like states and random glitches.
    for (int seg = 0; seg < 120; seg++) begin
      a = 6'($urandom_range(0, 63));
      repeat ($urandom_range(1, 40)) tick(a);
    end

    // Asynchronous reset in the middle of a qualification (cnt = 7).
    repeat (40) tick(6'h00);
    repeat (SYNC + 7) tick(6'h3F);
    #3;
    mon_en = 1'b0;
    iN_RESET = 1'b0;
    #1;
    check("async_rst_genpad", {26'd0, pad_if.oGENPAD}, 32'h3F);
    check("async_rst_idle", {31'd0, pad_if.oPAD_IDLE}, 32'd0);
    check("async_rst_glitch", {24'd0, pad_if.oGLITCH_COUNT}, 32'd0);
    exp_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
